// File: rtl/perf_monitor_unit.sv
// perf_monitor_unit
// Event-counting performance monitor for a small CPU core.
//
// Ports
//   clk                    : single clock, all state updates on the rising edge
//   reset                  : asynchronous active-low reset; zeros every register and output
//   retire                 : one instruction completed this cycle
//   aluFire / aluOp        : ALU operation this cycle and its op code
//   regAccess / regIdx     : register-file access this cycle and the register index
//   clear                  : synchronous clear of all statistics (snapshot registers are kept)
//   freeze                 : while high, events are ignored (snapshots still honoured)
//   snapReq                : capture the post-event totals into the snapshot registers
//   total*                 : live saturating totals, one cycle after the events
//   snap* / snapValid      : captured totals and a one-cycle pulse when they update
//   overflow               : sticky saturation flags {reg, alu, instr}
//   mostUsedReg/OpsALU     : index with the highest histogram count (ties keep the winner)
//   currentEstimatedPower  : weighted event sum of the last completed window, capped at 255
//
// Handshakes: there is no valid/ready pair; every input is a level sampled on
// each rising edge, and snapValid is a plain one-cycle pulse with no back-pressure.
module perf_monitor_unit #(
    parameter int CNT_W     = 32,
    parameter int HIST_W    = 16,
    parameter int REG_IDX_W = 5,
    parameter int OP_W      = 4,
    parameter int PWR_WIN   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 retire,
    input  logic                 aluFire,
    input  logic [OP_W-1:0]      aluOp,
    input  logic                 regAccess,
    input  logic [REG_IDX_W-1:0] regIdx,
    input  logic                 clear,
    input  logic                 freeze,
    input  logic                 snapReq,
    output logic [CNT_W-1:0]     totalInstructions,
    output logic [CNT_W-1:0]     totalOpsALU,
    output logic [CNT_W-1:0]     totalRegAccesses,
    output logic [CNT_W-1:0]     snapInstructions,
    output logic [CNT_W-1:0]     snapOpsALU,
    output logic [CNT_W-1:0]     snapRegAccesses,
    output logic                 snapValid,
    output logic [2:0]           overflow,
    output logic [REG_IDX_W-1:0] mostUsedReg,
    output logic [OP_W-1:0]      mostUsedOpsALU,
    output logic [7:0]           currentEstimatedPower
);

    localparam int NREG  = 1 << REG_IDX_W;
    localparam int NOP   = 1 << OP_W;
    localparam int WIN_W = (PWR_WIN > 2) ? $clog2(PWR_WIN) : 1;
    // 14 * 64 = 896 is the largest possible window sum; 11 bits leave headroom for the add.
    localparam int ACC_W = 11;

    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(PWR_WIN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [HIST_W-1:0] HIST_MAX = '1;

    logic [CNT_W-1:0]     r_tot_instr, r_tot_alu, r_tot_reg;
    logic [CNT_W-1:0]     w_nxt_instr, w_nxt_alu, w_nxt_reg;
    logic [2:0]           r_ovf, w_nxt_ovf;
    logic [CNT_W-1:0]     r_snap_instr, r_snap_alu, r_snap_reg;
    logic                 r_snap_valid;
    logic [HIST_W-1:0]    r_reg_hist [NREG];
    logic [HIST_W-1:0]    r_op_hist  [NOP];
    logic [REG_IDX_W-1:0] r_most_reg;
    logic [OP_W-1:0]      r_most_op;
    logic [WIN_W-1:0]     r_win_cnt;
    logic [ACC_W-1:0]     r_acc;
    logic [7:0]           r_power;

    logic                 w_ev_retire, w_ev_alu, w_ev_reg;
    logic [HIST_W-1:0]    w_reg_hist_inc, w_op_hist_inc;
    logic [ACC_W-1:0]     w_weight, w_acc_sum;

    // Frozen cycles see no events at all; clear is handled separately and wins.
    assign w_ev_retire = retire    & ~freeze;
    assign w_ev_alu    = aluFire   & ~freeze;
    assign w_ev_reg    = regAccess & ~freeze;

    assign w_reg_hist_inc = (r_reg_hist[regIdx] == HIST_MAX) ? HIST_MAX
                          : r_reg_hist[regIdx] + HIST_W'(1);
    assign w_op_hist_inc  = (r_op_hist[aluOp] == HIST_MAX) ? HIST_MAX
                          : r_op_hist[aluOp] + HIST_W'(1);

    assign w_weight  = freeze ? '0
                     : (ACC_W'({retire, 2'b00}) + ACC_W'({aluFire, 3'b000})
                        + ACC_W'({regAccess, 1'b0}));
    assign w_acc_sum = r_acc + w_weight;

    // Next-state totals are shared by the live registers and the snapshot
    // capture, so a snapshot reflects the events of its own cycle.
    always_comb begin
        w_nxt_instr = r_tot_instr;
        w_nxt_alu   = r_tot_alu;
        w_nxt_reg   = r_tot_reg;
        w_nxt_ovf   = r_ovf;
        if (clear) begin
            w_nxt_instr = '0;
            w_nxt_alu   = '0;
            w_nxt_reg   = '0;
            w_nxt_ovf   = '0;
        end else begin
            if (w_ev_retire) begin
                if (r_tot_instr == CNT_MAX) w_nxt_ovf[0] = 1'b1;
                else                        w_nxt_instr  = r_tot_instr + CNT_W'(1);
            end
            if (w_ev_alu) begin
                if (r_tot_alu == CNT_MAX) w_nxt_ovf[1] = 1'b1;
                else                      w_nxt_alu    = r_tot_alu + CNT_W'(1);
            end
            if (w_ev_reg) begin
                if (r_tot_reg == CNT_MAX) w_nxt_ovf[2] = 1'b1;
                else                      w_nxt_reg    = r_tot_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tot_instr  <= '0;
            r_tot_alu    <= '0;
            r_tot_reg    <= '0;
            r_ovf        <= '0;
            r_snap_instr <= '0;
            r_snap_alu   <= '0;
            r_snap_reg   <= '0;
            r_snap_valid <= 1'b0;
            r_most_reg   <= '0;
            r_most_op    <= '0;
            r_win_cnt    <= '0;
            r_acc        <= '0;
            r_power      <= '0;
            for (int i = 0; i < NREG; i++) r_reg_hist[i] <= '0;
            for (int i = 0; i < NOP; i++)  r_op_hist[i]  <= '0;
        end else begin
            r_tot_instr  <= w_nxt_instr;
            r_tot_alu    <= w_nxt_alu;
            r_tot_reg    <= w_nxt_reg;
            r_ovf        <= w_nxt_ovf;
            r_snap_valid <= snapReq;
            if (snapReq) begin
                r_snap_instr <= w_nxt_instr;
                r_snap_alu   <= w_nxt_alu;
                r_snap_reg   <= w_nxt_reg;
            end

            if (clear) begin
                r_most_reg <= '0;
                r_most_op  <= '0;
                r_win_cnt  <= '0;
                r_acc      <= '0;
                r_power    <= '0;
                for (int i = 0; i < NREG; i++) r_reg_hist[i] <= '0;
                for (int i = 0; i < NOP; i++)  r_op_hist[i]  <= '0;
            end else begin
                if (w_ev_reg) begin
                    r_reg_hist[regIdx] <= w_reg_hist_inc;
                    // Strictly greater: a tie leaves the current winner in place.
                    if (w_reg_hist_inc > r_reg_hist[r_most_reg]) r_most_reg <= regIdx;
                end
                if (w_ev_alu) begin
                    r_op_hist[aluOp] <= w_op_hist_inc;
                    if (w_op_hist_inc > r_op_hist[r_most_op]) r_most_op <= aluOp;
                end

                // Window counter free-runs even while frozen.
                if (r_win_cnt == WIN_LAST) begin
                    r_win_cnt <= '0;
                    r_acc     <= '0;
                    r_power   <= (w_acc_sum > ACC_W'(255)) ? 8'hFF : w_acc_sum[7:0];
                end else begin
                    r_win_cnt <= r_win_cnt + WIN_W'(1);
                    r_acc     <= w_acc_sum;
                end
            end
        end
    end

    assign totalInstructions     = r_tot_instr;
    assign totalOpsALU           = r_tot_alu;
    assign totalRegAccesses      = r_tot_reg;
    assign snapInstructions      = r_snap_instr;
    assign snapOpsALU            = r_snap_alu;
    assign snapRegAccesses       = r_snap_reg;
    assign snapValid             = r_snap_valid;
    assign overflow              = r_ovf;
    assign mostUsedReg           = r_most_reg;
    assign mostUsedOpsALU        = r_most_op;
    assign currentEstimatedPower = r_power;

endmodule

// File: tb/tb_perf_monitor_unit.sv
// tb_perf_monitor_unit
// Directed bench for perf_monitor_unit: a default-parameter instance plus a
// CNT_W=4 instance sharing the same stimulus for the saturation cases.
module tb_perf_monitor_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       retire = 1'b0, aluFire = 1'b0, regAccess = 1'b0;
    logic [3:0] aluOp = '0;
    logic [4:0] regIdx = '0;
    logic       clear = 1'b0, freeze = 1'b0, snapReq = 1'b0;

    logic [31:0] tot_i, tot_a, tot_r, snp_i, snp_a, snp_r;
    logic        snp_v;
    logic [2:0]  ovf;
    logic [4:0]  most_reg;
    logic [3:0]  most_op;
    logic [7:0]  power;

    logic [3:0]  s_tot_i, s_tot_a, s_tot_r, s_snp_i, s_snp_a, s_snp_r;
    logic        s_snp_v;
    logic [2:0]  s_ovf;
    logic [4:0]  s_most_reg;
    logic [3:0]  s_most_op;
    logic [7:0]  s_power;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    perf_monitor_unit dut (
        .clk(clk), .reset(reset), .retire(retire), .aluFire(aluFire), .aluOp(aluOp),
        .regAccess(regAccess), .regIdx(regIdx), .clear(clear), .freeze(freeze),
        .snapReq(snapReq),
        .totalInstructions(tot_i), .totalOpsALU(tot_a), .totalRegAccesses(tot_r),
        .snapInstructions(snp_i), .snapOpsALU(snp_a), .snapRegAccesses(snp_r),
        .snapValid(snp_v), .overflow(ovf), .mostUsedReg(most_reg),
        .mostUsedOpsALU(most_op), .currentEstimatedPower(power)
    );

    perf_monitor_unit #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .retire(retire), .aluFire(aluFire), .aluOp(aluOp),
        .regAccess(regAccess), .regIdx(regIdx), .clear(clear), .freeze(freeze),
        .snapReq(snapReq),
        .totalInstructions(s_tot_i), .totalOpsALU(s_tot_a), .totalRegAccesses(s_tot_r),
        .snapInstructions(s_snp_i), .snapOpsALU(s_snp_a), .snapRegAccesses(s_snp_r),
        .snapValid(s_snp_v), .overflow(s_ovf), .mostUsedReg(s_most_reg),
        .mostUsedOpsALU(s_most_op), .currentEstimatedPower(s_power)
    );

    // ---------------- driver / check tasks ----------------
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_ev(input logic r, input logic a, input logic g);
        retire = r; aluFire = a; regAccess = g;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        #2 reset = 1'b0;
        tick(2);
        chk("rst_tot_i", tot_i, 0);
        chk("rst_tot_r", tot_r, 0);
        chk("rst_snap_v", snp_v, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_power", power, 0);
        @(negedge clk);
        reset = 1'b1;

        // All events high, op 3 / reg 7.
        aluOp = 4'd3; regIdx = 5'd7; set_ev(1, 1, 1);
        tick(1);
        chk("latency_tot_i", tot_i, 1);
        tick(9);
        chk("ten_tot_i", tot_i, 10);
        chk("ten_tot_a", tot_a, 10);
        chk("ten_tot_r", tot_r, 10);
        chk("ten_most_op", most_op, 3);
        chk("ten_most_reg", most_reg, 7);
        tick(5);
        chk("pre_wrap_power", power, 0);
        chk("w4_ovf_before", s_ovf, 0);
        chk("w4_tot_i_at15", s_tot_i, 15);
        tick(1);
        chk("full_win_power", power, 224);
        chk("w4_sat_tot_i", s_tot_i, 15);
        chk("w4_ovf_set", s_ovf, 3'b111);
        chk("tot_i_16", tot_i, 16);

        // Clear wins over same-cycle events.
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("clr_tot_i", tot_i, 0);
        chk("clr_power", power, 0);
        chk("clr_most_reg", most_reg, 0);
        chk("clr_most_op", most_op, 0);
        chk("w4_clr_tot_i", s_tot_i, 0);
        chk("w4_clr_ovf", s_ovf, 0);

        // Fresh window: reg accesses on 5 cycles (2,2,2,5,5), then idle.
        set_ev(0, 0, 1); regIdx = 5'd2;
        tick(3);
        chk("hist_most_reg_2", most_reg, 2);
        regIdx = 5'd5;
        tick(2);
        set_ev(0, 0, 0);
        tick(10);
        chk("win5_power_pre", power, 0);
        tick(1);
        chk("win5_power", power, 10);
        chk("win5_tot_r", tot_r, 5);
        chk("tie_most_reg_2", most_reg, 2);
        set_ev(0, 0, 1);
        tick(1);
        chk("tie3_most_reg_2", most_reg, 2);
        tick(1);
        chk("beat_most_reg_5", most_reg, 5);

        // Plain snapshot including this cycle's retire.
        set_ev(1, 0, 0); snapReq = 1'b1;
        tick(1);
        chk("snap_v", snp_v, 1);
        chk("snap_i", snp_i, 1);
        chk("snap_r", snp_r, 7);
        chk("snap_a", snp_a, 0);
        set_ev(0, 0, 0); snapReq = 1'b0;
        tick(1);
        chk("snap_v_drop", snp_v, 0);

        // Frozen: events ignored, snapshot still taken.
        freeze = 1'b1; set_ev(1, 1, 1); aluOp = 4'd9; regIdx = 5'd3;
        tick(1);
        snapReq = 1'b1;
        tick(1);
        chk("frz_snap_v", snp_v, 1);
        chk("frz_snap_i", snp_i, 1);
        chk("frz_snap_r", snp_r, 7);
        snapReq = 1'b0;
        tick(1);
        chk("frz_snap_v_drop", snp_v, 0);
        tick(1);
        chk("frz_tot_i", tot_i, 1);
        chk("frz_tot_a", tot_a, 0);
        chk("frz_tot_r", tot_r, 7);
        chk("frz_most_op", most_op, 0);
        chk("frz_most_reg", most_reg, 5);
        freeze = 1'b0;

        // Back-to-back snapshots.
        set_ev(1, 0, 0); snapReq = 1'b1;
        tick(1);
        chk("b2b_v1", snp_v, 1);
        chk("b2b_i1", snp_i, 2);
        tick(1);
        chk("b2b_v2", snp_v, 1);
        chk("b2b_i2", snp_i, 3);
        set_ev(0, 0, 0); snapReq = 1'b0;

        // Clear keeps snapshots; clear with snapReq captures zeros.
        clear = 1'b1;
        tick(1);
        chk("clr_keep_snap", snp_i, 3);
        chk("clr_tot_i2", tot_i, 0);
        snapReq = 1'b1;
        tick(1);
        chk("clr_snap_zero", snp_i, 0);
        chk("clr_snap_v", snp_v, 1);
        clear = 1'b0; snapReq = 1'b0;

        // Mid-count asynchronous reset.
        set_ev(1, 0, 0);
        tick(1);
        snapReq = 1'b1;
        tick(1);
        snapReq = 1'b0;
        tick(1);
        chk("pre_rst_tot_i", tot_i, 3);
        chk("pre_rst_snap_i", snp_i, 2);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_tot_i", tot_i, 0);
        chk("arst_snap_i", snp_i, 0);
        chk("w4_arst_tot_i", s_tot_i, 0);

        // First window after reset is a full window; partial sum discarded.
        @(negedge clk);
        reset = 1'b1;
        set_ev(1, 1, 1);
        tick(15);
        chk("post_rst_power_pre", power, 0);
        tick(1);
        chk("post_rst_power", power, 224);
        set_ev(0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #100000;
        $display("FAIL timeout observed=stalled expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/perf_monitor_unit.md
PERF_MONITOR_UNIT -- requirements
Module: perf_monitor_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 32, total-counter width.
REQ-002 SHALL have parameter HIST_W, default 16, per-index histogram counter width.
REQ-003 SHALL have parameter REG_IDX_W, default 5, register index width (2^REG_IDX_W registers).
REQ-004 SHALL have parameter OP_W, default 4, ALU op code width (2^OP_W ops).
REQ-005 SHALL have parameter PWR_WIN, default 16, power window length in cycles (power of two, 2..64).
REQ-006 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port retire  in  1  one instruction completed this cycle.
REQ-009 SHALL have port aluFire  in  1  ALU performed an operation this cycle.
REQ-010 SHALL have port aluOp  in  OP_W  op code for aluFire.
REQ-011 SHALL have port regAccess  in  1  register file accessed this cycle.
REQ-012 SHALL have port regIdx  in  REG_IDX_W  register index for regAccess.
REQ-013 SHALL have port clear  in  1  synchronous clear of all statistics.
REQ-014 SHALL have port freeze  in  1  ignore all events while high.
REQ-015 SHALL have port snapReq  in  1  capture totals into snapshot registers.
REQ-016 SHALL have ports totalInstructions, totalOpsALU, totalRegAccesses  out  CNT_W each  live totals.
REQ-017 SHALL have port snapInstructions, snapOpsALU, snapRegAccesses  out  CNT_W each  captured totals.
REQ-018 SHALL have port snapValid  out  1  one-cycle pulse when snapshot updated.
REQ-019 SHALL have port overflow  out  3  sticky saturation flags {reg, alu, instr}.
REQ-020 SHALL have ports mostUsedReg  out  REG_IDX_W and mostUsedOpsALU  out  OP_W.
REQ-021 SHALL have port currentEstimatedPower  out  8  last completed-window power estimate.

Function
REQ-022 Event sampled in cycle N SHALL be visible on live outputs in cycle N+1 (one-cycle latency).
REQ-023 Each total SHALL increment by 1 per qualifying event and saturate at 2^CNT_W-1; attempted increment at max SHALL set its overflow bit, which stays set until clear or reset.
REQ-024 Histograms: one HIST_W counter per register index and per op code, incremented on regAccess/aluFire, saturating at max without overflow flag.
REQ-025 On histogram increment of index i, if new count of i > current count of mostUsed index, mostUsed SHALL become i next cycle; ties keep current winner; after reset/clear winner is 0.
REQ-026 Power: per cycle weight = 4*retire + 8*aluFire + 2*regAccess, accumulated over PWR_WIN cycles by a free-running window counter 0..PWR_WIN-1.
REQ-027 When window counter wraps PWR_WIN-1 -> 0, currentEstimatedPower SHALL load min(255, accumulator incl. that cycle's weight) and accumulator SHALL restart at 0.
REQ-028 Window counter SHALL run regardless of freeze; frozen cycles contribute weight 0.
REQ-029 freeze high: totals, histograms, mostUsed, overflow unchanged; snapReq still honoured.
REQ-030 snapReq in cycle N: snap outputs SHALL hold totals as they are after cycle N's events in cycle N+1, snapValid high exactly in N+1; back-to-back requests pulse each cycle.
REQ-031 clear: totals, histograms, overflow, mostUsed, accumulator, window counter, currentEstimatedPower SHALL be 0 next cycle; clear has priority over same-cycle events and freeze; snap outputs retained; snapReq with clear captures zeros.
REQ-032 Simultaneous retire, aluFire, regAccess in one cycle SHALL all be counted.

Reset
REQ-033 reset low SHALL immediately zero every register and output, including snap outputs and snapValid, regardless of clk.
REQ-034 Reset asserted mid-window SHALL discard partial accumulation; first window after release is a full PWR_WIN cycles.

Verification
REQ-035 Reset, then 10 cycles retire=aluFire=regAccess=1, aluOp=3, regIdx=7 -> totals 10, mostUsedOpsALU=3, mostUsedReg=7.
REQ-036 Full PWR_WIN=16 window all events high -> currentEstimatedPower=224; window with only regAccess on 5 cycles -> 10.
REQ-037 CNT_W=4: 16 retire pulses -> totalInstructions=15, overflow[0]=1; then clear -> 0 and overflow=0.
REQ-038 regIdx 2 accessed 3x, then regIdx 5 accessed 3x -> mostUsedReg stays 2; fourth access of 5 -> 5.
REQ-039 freeze high with 4 retires plus snapReq -> totals unchanged, snapValid pulses once, snap equals pre-freeze totals.
REQ-040 Assert reset asynchronously between clock edges mid-count -> all outputs 0 before next rising edge.
